// File: rtl/axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_arb_pkg
// Shared definitions for the AXI read arbiter: AR state encoding and the
// fixed AXI field widths used when flattening per-port request buses.
// ---------------------------------------------------------------------------
package axi_arb_pkg;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    // IDLE chooses a requester; GRANT holds its request on the downstream AR
    // channel until it is accepted.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } ar_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first requesting port found
// when scanning upward from ptr, wrapping past the top port.
//
// Ports:
//   req          in   NUM_PORTS  request vector
//   ptr          in   SEL_W      port with highest priority this round
//   grant_onehot out  NUM_PORTS  one-hot form of the pick (0 when no request)
//   grant_idx    out  SEL_W      index of the pick (0 when no request)
//   grant_valid  out  1          at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int  NUM_PORTS = 2,
    localparam int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant_onehot,
    output logic [SEL_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [SEL_W-1:0] cand;

    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the tool infers a latch to hold the old value.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        cand         = '0;
        // Scan from the farthest offset down to the nearest so the port
        // closest to ptr is the last (and therefore winning) assignment.
        // NUM_PORTS is a power of two, so SEL_W-bit addition wraps for free.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                grant_onehot       = '0;
                grant_onehot[cand] = 1'b1;
                grant_idx          = cand;
                grant_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
// Merges NUM_PORTS upstream AXI read-address channels onto one downstream
// master using round-robin selection, tags the downstream ID with the port
// index in its top SEL_W bits, and routes read data back by that tag.
// Each port may have at most MAX_OUTSTANDING bursts in flight.
//
// Ports:
//   ap_clk, ap_rst_n                 clock, async active-low reset
//   in_AR*    (VALID/READY per port, payload flattened NUM_PORTS x field)
//   in_R*     (VALID per port, READY per port, payload broadcast)
//   out_AR*   downstream read-address channel
//   out_R*    downstream read-data channel
//   err_underflow  sticky: RLAST returned to a port with nothing in flight
// ---------------------------------------------------------------------------
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int  NUM_PORTS          = 2,
    parameter int  C_M_AXI_ID_WIDTH   = 8,
    parameter int  C_M_AXI_ADDR_WIDTH = 32,
    parameter int  C_M_AXI_DATA_WIDTH = 512,
    parameter int  MAX_OUTSTANDING    = 16,
    localparam int SEL_W              = $clog2(NUM_PORTS),
    localparam int UID_W              = C_M_AXI_ID_WIDTH - SEL_W
) (
    input  logic                                   ap_clk,
    input  logic                                   ap_rst_n,
    // upstream AR
    input  logic [NUM_PORTS-1:0]                   in_ARVALID,
    output logic [NUM_PORTS-1:0]                   in_ARREADY,
    input  logic [NUM_PORTS*C_M_AXI_ADDR_WIDTH-1:0] in_ARADDR,
    input  logic [NUM_PORTS*UID_W-1:0]             in_ARID,
    input  logic [NUM_PORTS*LEN_W-1:0]             in_ARLEN,
    input  logic [NUM_PORTS*SIZE_W-1:0]            in_ARSIZE,
    input  logic [NUM_PORTS*BURST_W-1:0]           in_ARBURST,
    // upstream R
    output logic [NUM_PORTS-1:0]                   in_RVALID,
    input  logic [NUM_PORTS-1:0]                   in_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]          in_RDATA,
    output logic                                   in_RLAST,
    output logic [UID_W-1:0]                       in_RID,
    output logic [RESP_W-1:0]                      in_RRESP,
    // downstream AR
    output logic                                   out_ARVALID,
    input  logic                                   out_ARREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]          out_ARADDR,
    output logic [C_M_AXI_ID_WIDTH-1:0]            out_ARID,
    output logic [LEN_W-1:0]                       out_ARLEN,
    output logic [SIZE_W-1:0]                      out_ARSIZE,
    output logic [BURST_W-1:0]                     out_ARBURST,
    // downstream R
    input  logic                                   out_RVALID,
    output logic                                   out_RREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]          out_RDATA,
    input  logic                                   out_RLAST,
    input  logic [C_M_AXI_ID_WIDTH-1:0]            out_RID,
    input  logic [RESP_W-1:0]                      out_RRESP,
    // status
    output logic                                   err_underflow
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    ar_state_e              state, state_nxt;
    logic [SEL_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [SEL_W-1:0]       grant, grant_nxt;
    logic [NUM_PORTS-1:0]   grant_oh, grant_oh_nxt;
    logic [CNT_W-1:0]       outstanding [NUM_PORTS];

    logic [NUM_PORTS-1:0]   eligible;
    logic [NUM_PORTS-1:0]   pick_oh;
    logic [SEL_W-1:0]       pick_idx;
    logic                   pick_valid;

    logic                   ar_fire;
    logic                   r_last_fire;
    logic [SEL_W-1:0]       r_sel;
    logic [NUM_PORTS-1:0]   cnt_inc, cnt_dec;

    // ------------------------------------------------------------------ AR --
    // A port at its in-flight limit is invisible to the arbiter, which is
    // what keeps the counters from ever passing MAX_OUTSTANDING.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = in_ARVALID[p] && (outstanding[p] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .req          (eligible),
        .ptr          (rr_ptr),
        .grant_onehot (pick_oh),
        .grant_idx    (pick_idx),
        .grant_valid  (pick_valid)
    );

    assign ar_fire = (state == ST_GRANT) && out_ARREADY;

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant;
        grant_oh_nxt = grant_oh;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_nxt    = pick_idx;
                    grant_oh_nxt = pick_oh;
                    state_nxt    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (out_ARREADY) begin
                    rr_ptr_nxt = grant + 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            grant_oh <= NUM_PORTS'(1);
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant    <= grant_nxt;
            grant_oh <= grant_oh_nxt;
        end
    end

    // State is reset asynchronously, so VALID/READY drop the moment reset
    // asserts without needing a separate gate.
    assign out_ARVALID = (state == ST_GRANT);
    assign in_ARREADY  = ar_fire ? grant_oh : '0;
    assign out_ARADDR  = in_ARADDR[grant*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
    assign out_ARID    = {grant, in_ARID[grant*UID_W +: UID_W]};
    assign out_ARLEN   = in_ARLEN[grant*LEN_W +: LEN_W];
    assign out_ARSIZE  = in_ARSIZE[grant*SIZE_W +: SIZE_W];
    assign out_ARBURST = in_ARBURST[grant*BURST_W +: BURST_W];

    // ------------------------------------------------------------------- R --
    assign r_sel       = out_RID[C_M_AXI_ID_WIDTH-1 -: SEL_W];
    assign out_RREADY  = in_RREADY[r_sel];
    assign in_RDATA    = out_RDATA;
    assign in_RLAST    = out_RLAST;
    assign in_RRESP    = out_RRESP;
    assign in_RID      = out_RID[UID_W-1:0];
    assign r_last_fire = out_RVALID && out_RREADY && out_RLAST;

    always_comb begin
        in_RVALID = '0;
        if (out_RVALID) in_RVALID[r_sel] = 1'b1;
    end

    // ------------------------------------------------- in-flight counters --
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_inc[p] = ar_fire && grant_oh[p];
            cnt_dec[p] = r_last_fire && (r_sel == SEL_W'(p));
        end
    end

    // NOTE: the counter array is a handful of flops, not a RAM, so each entry
    // is cleared explicitly in the reset branch.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) outstanding[p] <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (cnt_inc[p] && !cnt_dec[p]) begin
                    outstanding[p] <= outstanding[p] + CNT_W'(1);
                end else if (cnt_dec[p] && !cnt_inc[p]) begin
                    // A burst end with nothing in flight is a protocol error;
                    // flag it and keep the counter pinned at zero.
                    if (outstanding[p] == '0) err_underflow <= 1'b1;
                    else                      outstanding[p] <= outstanding[p] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of upstream read requesters (power of 2, 2..8).
REQ-002 SHALL have parameter C_M_AXI_ID_WIDTH, default 8, downstream ID width.
REQ-003 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32; C_M_AXI_DATA_WIDTH, default 512.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 16, per-port in-flight burst limit.
REQ-005 SHALL derive SEL_W = $clog2(NUM_PORTS) and UID_W = C_M_AXI_ID_WIDTH - SEL_W (upstream ID width).
REQ-006 SHALL use one clock and an asynchronous active-low reset: ap_clk input 1 (rising edge), ap_rst_n input 1 (async, active-low).
REQ-007 in_ARVALID input NUM_PORTS; in_ARREADY output NUM_PORTS; per-port request handshake.
REQ-008 in_ARADDR/in_ARID/in_ARLEN/in_ARSIZE/in_ARBURST inputs, flattened NUM_PORTS x {ADDR, UID_W, 8, 3, 2}.
REQ-009 in_RVALID output NUM_PORTS; in_RREADY input NUM_PORTS; in_RDATA/in_RLAST/in_RID/in_RRESP outputs, broadcast {DATA, 1, UID_W, 2}.
REQ-010 out_ARVALID output 1; out_ARREADY input 1; out_ARADDR/ID/LEN/SIZE/BURST outputs {ADDR, ID, 8, 3, 2}.
REQ-011 out_RVALID input 1; out_RREADY output 1; out_RDATA/RLAST/RID/RRESP inputs {DATA, 1, ID, 2}.
REQ-012 err_underflow output 1, sticky protocol-error flag.

Function
REQ-013 AR FSM states IDLE and GRANT; IDLE selects a port, GRANT presents it downstream.
REQ-014 Port p eligible in IDLE iff in_ARVALID[p]=1 and outstanding[p] < MAX_OUTSTANDING.
REQ-015 In IDLE, round-robin pick: first eligible port starting at rr_ptr, ascending, wrapping; registered grant, go to GRANT next cycle.
REQ-016 In IDLE with no eligible port, remain IDLE; out_ARVALID=0, all in_ARREADY=0.
REQ-017 In GRANT, out_ARVALID=1, payload = granted port fields, out_ARID = {grant, in_ARID[grant]}; in_ARREADY[grant]=out_ARREADY, others 0.
REQ-018 On out_ARVALID&out_ARREADY: go IDLE, rr_ptr <= grant+1 mod NUM_PORTS; GRANT holds indefinitely otherwise.
REQ-019 AR latency: in_ARVALID to out_ARVALID = 1 cycle; maximum throughput one AR per 2 cycles.
REQ-020 R routing combinational: sel = out_RID[ID-1 -: SEL_W]; in_RVALID[sel]=out_RVALID, others 0; out_RREADY=in_RREADY[sel].
REQ-021 in_RDATA/RLAST/RRESP = out_R fields; in_RID = out_RID[UID_W-1:0].
REQ-022 outstanding[p] +1 on AR handshake of port p; -1 on R handshake to p with RLAST=1; both same cycle: unchanged.
REQ-023 Counter width $clog2(MAX_OUTSTANDING+1); never exceeds MAX_OUTSTANDING (eligibility gate).
REQ-024 RLAST handshake to port with outstanding=0: counter stays 0, err_underflow <= 1 until reset.

Reset
REQ-025 ap_rst_n low asynchronously forces: state IDLE, rr_ptr 0, grant 0, outstanding all 0, err_underflow 0.
REQ-026 During reset out_ARVALID=0 and in_ARREADY=0 immediately; R routing remains combinational.
REQ-027 Reset mid-GRANT abandons the pending AR; after release arbitration restarts from port 0.

Structure
REQ-028 Shared package axi_arb_pkg SHALL hold the FSM state enum and AXI field width constants (LEN 8, SIZE 3, BURST 2, RESP 2).
REQ-029 Sub-module rr_arbiter (NUM_PORTS request vector, pointer in, one-hot/index grant out, combinational) SHALL implement REQ-015.
REQ-030 Total RTL SHALL fit 120-400 lines; no memories, no dont_touch attributes.

Verification
REQ-031 Both ports ARVALID continuously, out_ARREADY=1 -> grants alternate 0,1,0,1; out_ARID top bit alternates; one AR per 2 cycles.
REQ-032 Port 1 ARVALID with in_ARID=0x15, out_ARREADY held 0 for 5 cycles -> out_ARVALID steady, out_ARID=0x95, in_ARREADY[1]=0 until release.
REQ-033 Port 0 issues 16 ARs, no R -> 17th not granted; one RLAST beat to port 0 -> next AR granted within 2 cycles.
REQ-034 out_RVALID with out_RID=0x83, in_RREADY[1]=0 -> in_RVALID[1]=1, in_RID=0x03, out_RREADY=0; in_RREADY[1]=1 -> out_RREADY=1.
REQ-035 RLAST beat to port 0 with outstanding 0 -> err_underflow=1 next cycle, stays 1; ap_rst_n pulse -> 0.
REQ-036 ap_rst_n asserted while GRANT -> out_ARVALID falls same cycle; counters 0; after release port 0 wins first.
